data_ram_arbiter: RTL and testbench
===================================

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, giving the data word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, giving the RAM address width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Ports req0/req1, input, 1: access request from requester 0 (core) and requester 1 (loader/DMA).
REQ-007 Ports we0/we1, input, 1: 1 means write, 0 means read, per requester.
REQ-008 Ports addr0/addr1, input, ADDR_WIDTH: access address, per requester.
REQ-009 Ports wdata0/wdata1, input, DWIDTH: write data, per requester.
REQ-010 Ports ack0/ack1, output, 1: one-cycle completion pulse, per requester.
REQ-011 Ports rdata0/rdata1, output, DWIDTH: registered read data, per requester.
REQ-012 Port ram_addr, output, ADDR_WIDTH: address to the data RAM.
REQ-013 Port ram_data, output, DWIDTH: write data to the data RAM.
REQ-014 Port ram_we, output, 1: write enable to the data RAM.
REQ-015 Port ram_dout, input, DWIDTH: combinational read data from the data RAM, valid while ram_we=0.
REQ-016 Port busy, output, 1: high in ACCESS and RESP.
REQ-017 Port owner, output, 1: index of the current or last granted requester.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-019 IDLE SHALL go to ACCESS at the next edge when req0 or req1 is high, latching the winner into owner.
REQ-020 Arbitration SHALL be round-robin: with both requests high, the requester not equal to last_served wins; with one request high, that requester wins.
REQ-021 last_served SHALL update to owner on every ACCESS->RESP transition.
REQ-022 In ACCESS, ram_addr, ram_data and ram_we SHALL be driven combinationally from the owner's addr, wdata and we.
REQ-023 Outside ACCESS, ram_we SHALL be 0, and ram_addr and ram_data SHALL be 0.
REQ-024 ACCESS SHALL last exactly one cycle and then go to RESP.
REQ-025 For a read, rdata[owner] SHALL capture ram_dout at the ACCESS->RESP edge; a write SHALL leave rdata unchanged.
REQ-026 ack[owner] SHALL be high for exactly the RESP cycle; the other ack SHALL stay 0.
REQ-027 Requesters SHALL hold req, we, addr and wdata stable from assertion until they see ack, and SHALL drop req in the ack cycle or later.
REQ-028 In RESP, the owner's req SHALL be ignored; if the non-owner's req is high, RESP SHALL go to ACCESS with owner switched, otherwise RESP SHALL go to IDLE.
REQ-029 Latency: req high at edge k gives ACCESS in cycle k+1 and ack in cycle k+2; sustained alternating traffic gives one access per 2 cycles.
REQ-030 A requester whose req stays high after its ack SHALL be treated as a new request only once back in IDLE.
REQ-031 A request that drops before it is granted SHALL produce no RAM access and no ack.

Reset
REQ-032 While rst_n=0, the block SHALL force state=IDLE, owner=0, last_served=1, ack0=ack1=0, rdata0=rdata1=0, busy=0 and ram_we=0.
REQ-033 Reset asserted during ACCESS SHALL abort the access immediately, with ram_we dropping asynchronously, and SHALL produce no ack.
REQ-034 The first cycle after rst_n rises SHALL arbitrate normally, with requester 0 winning a tie.

Verification
REQ-035 Reset, then req0 only, write addr=0x0004, wdata=0xBEEF -> ram_we=1 and ram_addr=0x0004 in cycle 1, ack0 in cycle 2, rdata0 stays 0.
REQ-036 Then req0 only, read addr=0x0004, with the RAM model returning 0xBEEF -> rdata0=0xBEEF with ack0, 2 cycles after request.
REQ-037 req0 and req1 both high from reset -> grant order 0,1,0,1 with the sequence ACCESS, RESP, ACCESS, RESP and no IDLE between grants.
REQ-038 req1 only, held high for 3 back-to-back requests -> each request follows IDLE->ACCESS->RESP, i.e. ack1 every 3 cycles.
REQ-039 rst_n pulsed low mid-ACCESS of a write -> ram_we=0 at once, no ack, state IDLE, owner=0.
REQ-040 req1 pulsed for 1 cycle while the FSM is in ACCESS for owner 0 and dropped before RESP -> no access for requester 1 and ack1 never asserts.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// Two-requester round-robin arbiter for a single-port data RAM.
// Each granted access takes one ACCESS cycle followed by a one-cycle RESP/ack.
module data_ram_arbiter #(
   parameter int DWIDTH     = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DWIDTH-1:0]     wdata0,
   input  logic [DWIDTH-1:0]     wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic [DWIDTH-1:0]     rdata0,
   output logic [DWIDTH-1:0]     rdata1,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0]     ram_data,
   output logic                  ram_we,
   input  logic [DWIDTH-1:0]     ram_dout,
   output logic                  busy,
   output logic                  owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                  state;
   logic                    last_served;
   logic                    winner;
   logic                    other_req;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DWIDTH-1:0]       sel_wdata;

   // With both requesting, the one not served last wins; otherwise the lone requester.
   always_comb begin
      winner = req1;
      if (req0 && req1) begin
         winner = ~last_served;
      end
   end

   always_comb begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
      other_req = req1;
      if (owner) begin
         sel_we    = we1;
         sel_addr  = addr1;
         sel_wdata = wdata1;
         other_req = req0;
      end
   end

   // RAM controls decode straight from the state register so reset kills them at once.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_data = '0;
      if (state == ACCESS) begin
         ram_we   = sel_we;
         ram_addr = sel_addr;
         ram_data = sel_wdata;
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_served <= 1'b1;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner <= winner;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               state       <= RESP;
               last_served <= owner;
               if (owner) begin
                  ack1 <= 1'b1;
                  if (!sel_we) begin
                     rdata1 <= ram_dout;
                  end
               end else begin
                  ack0 <= 1'b1;
                  if (!sel_we) begin
                     rdata0 <= ram_dout;
                  end
               end
            end
            RESP: begin
               // The owner's own req is ignored here; it re-arbitrates from IDLE.
               if (other_req) begin
                  owner <= ~owner;
                  state <= ACCESS;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios, then random traffic checked
// against a transaction-level memory model and round-robin/latency rules.
module tb_data_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1, wdata0, wdata1;
   logic        ack0, ack1;
   logic [15:0] rdata0, rdata1;
   logic [15:0] ram_addr, ram_data, ram_dout;
   logic        ram_we;
   logic        busy, owner;

   logic [15:0] mem [0:255] = '{default: 16'h0000};
   logic [15:0] ref_mem [0:7] = '{default: 16'h0000};

   int tests_run    = 0;
   int tests_failed = 0;

   data_ram_arbiter #(.DWIDTH(16), .ADDR_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
      .ram_dout(ram_dout), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   // Simple RAM: combinational read, write on the rising edge.
   assign ram_dout = mem[ram_addr[7:0]];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_data;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0,
                                input logic [15:0] d0, input logic r1, input logic w1,
                                input logic [15:0] a1, input logic [15:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   logic        pending [2];
   logic        p_we    [2];
   logic [15:0] p_addr  [2];
   logic [15:0] p_wdata [2];
   logic [15:0] exp_rd  [2];
   int          waitc   [2];
   logic        last_grant;
   logic        both_prev;
   logic        new_access;
   logic        obs_ack;
   logic [15:0] obs_rd;

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk); @(negedge clk);
      checkOutput("reset_owner", 32'(owner), 32'(0));
      checkOutput("reset_busy", 32'(busy), 32'(0));
      checkOutput("reset_ack0", 32'(ack0), 32'(0));
      checkOutput("reset_ack1", 32'(ack1), 32'(0));
      checkOutput("reset_rdata0", 32'(rdata0), 32'(0));
      checkOutput("reset_rdata1", 32'(rdata1), 32'(0));
      checkOutput("reset_ram_we", 32'(ram_we), 32'(0));
      rst_n = 1'b1;

      // Write 0xBEEF to 0x0004 from requester 0
      applyStimulus(1, 1, 16'h0004, 16'hBEEF, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("wr_busy", 32'(busy), 32'(1));
      checkOutput("wr_ram_we", 32'(ram_we), 32'(1));
      checkOutput("wr_ram_addr", 32'(ram_addr), 32'h0004);
      checkOutput("wr_ram_data", 32'(ram_data), 32'hBEEF);
      checkOutput("wr_ack0_early", 32'(ack0), 32'(0));
      @(negedge clk);
      checkOutput("wr_ack0", 32'(ack0), 32'(1));
      checkOutput("wr_ack1", 32'(ack1), 32'(0));
      checkOutput("wr_rdata0", 32'(rdata0), 32'(0));
      checkOutput("wr_resp_ram_we", 32'(ram_we), 32'(0));
      ref_mem[4] = 16'hBEEF;
      applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("wr_idle_busy", 32'(busy), 32'(0));
      checkOutput("wr_idle_ack0", 32'(ack0), 32'(0));

      // Read back 0x0004
      applyStimulus(1, 0, 16'h0004, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("rd_ram_we", 32'(ram_we), 32'(0));
      checkOutput("rd_ram_addr", 32'(ram_addr), 32'h0004);
      @(negedge clk);
      checkOutput("rd_ack0", 32'(ack0), 32'(1));
      checkOutput("rd_rdata0", 32'(rdata0), 32'hBEEF);
      applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("rd_idle_busy", 32'(busy), 32'(0));

      // Both requesting from reset: grants alternate 0,1,0,1 with no IDLE gap
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1, 0, 16'h0001, 16'h0, 1, 0, 16'h0002, 16'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("rr_owner", 32'(owner), 32'((k / 2) % 2));
         checkOutput("rr_busy", 32'(busy), 32'(1));
         checkOutput("rr_ack0", 32'(ack0), 32'((k % 2 == 1) && ((k / 2) % 2 == 0)));
         checkOutput("rr_ack1", 32'(ack1), 32'((k % 2 == 1) && ((k / 2) % 2 == 1)));
      end
      applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("rr_end_busy", 32'(busy), 32'(0));

      // req1 held high: one access every three cycles through IDLE
      applyStimulus(0, 0, 16'h0, 16'h0, 1, 0, 16'h0003, 16'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("hold_ack1", 32'(ack1), 32'(k % 3 == 1));
         checkOutput("hold_busy", 32'(busy), 32'(k % 3 != 2));
         checkOutput("hold_ack0", 32'(ack0), 32'(0));
      end
      applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("hold_end_busy", 32'(busy), 32'(0));

      // Reset in the middle of a write access
      applyStimulus(1, 1, 16'h0009, 16'h1234, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("abort_pre_we", 32'(ram_we), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_ram_we", 32'(ram_we), 32'(0));
      checkOutput("abort_busy", 32'(busy), 32'(0));
      checkOutput("abort_owner", 32'(owner), 32'(0));
      checkOutput("abort_ack0", 32'(ack0), 32'(0));
      applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("abort_no_write", 32'(mem[9]), 32'(0));
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("abort_no_ack", 32'(ack0 | ack1), 32'(0));
      end

      // req1 pulses during owner 0's access and drops before RESP
      applyStimulus(1, 0, 16'h0005, 16'h0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("pulse_owner", 32'(owner), 32'(0));
      applyStimulus(1, 0, 16'h0005, 16'h0, 1, 0, 16'h0006, 16'h0);
      @(negedge clk);
      checkOutput("pulse_ack0", 32'(ack0), 32'(1));
      checkOutput("pulse_ack1_resp", 32'(ack1), 32'(0));
      applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("pulse_ack1", 32'(ack1), 32'(0));
         checkOutput("pulse_busy", 32'(busy), 32'(0));
         checkOutput("pulse_ram_we", 32'(ram_we), 32'(0));
      end

      // Random traffic from a clean reset
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      last_grant = 1'b1;
      both_prev  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pending[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0;
         p_wdata[i] = '0; exp_rd[i] = '0; waitc[i] = 0;
      end
      for (int cyc = 0; cyc < 3040; cyc++) begin
         @(negedge clk);
         new_access = busy && !ack0 && !ack1;
         checkOutput("ack_exclusive", 32'(ack0 & ack1), 32'(0));
         if (new_access) begin
            checkOutput("grant_pending", 32'(pending[owner]), 32'(1));
            checkOutput("access_we", 32'(ram_we), 32'(p_we[owner]));
            checkOutput("access_addr", 32'(ram_addr), 32'(p_addr[owner]));
            checkOutput("access_data", 32'(ram_data), 32'(p_wdata[owner]));
            if (both_prev) checkOutput("round_robin", 32'(owner), 32'(!last_grant));
            last_grant = owner;
         end else begin
            checkOutput("quiet_ram_we", 32'(ram_we), 32'(0));
            checkOutput("quiet_ram_addr", 32'(ram_addr), 32'(0));
         end
         for (int i = 0; i < 2; i++) begin
            obs_ack = (i == 0) ? ack0 : ack1;
            obs_rd  = (i == 0) ? rdata0 : rdata1;
            if (obs_ack) begin
               checkOutput("ack_expected", 32'(pending[i]), 32'(1));
               if (pending[i]) begin
                  if (p_we[i]) ref_mem[p_addr[i][2:0]] = p_wdata[i];
                  else exp_rd[i] = ref_mem[p_addr[i][2:0]];
                  checkOutput("rdata", 32'(obs_rd), 32'(exp_rd[i]));
                  pending[i] = 1'b0;
               end
            end else if (pending[i]) begin
               waitc[i]++;
               checkOutput("latency", 32'(waitc[i] <= 6), 32'(1));
            end
            if (!pending[i] && cyc < 3000 && $urandom_range(0, 2) == 0) begin
               pending[i] = 1'b1;
               waitc[i]   = 0;
               p_we[i]    = 1'($urandom_range(0, 1));
               p_addr[i]  = 16'($urandom_range(0, 7));
               p_wdata[i] = 16'($urandom);
            end
         end
         applyStimulus(pending[0], p_we[0], p_addr[0], p_wdata[0],
                       pending[1], p_we[1], p_addr[1], p_wdata[1]);
         both_prev = pending[0] && pending[1];
      end
      checkOutput("drained", 32'(pending[0] | pending[1]), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
